// File: rtl/dm_store_buffer.sv
// Memory-stage store buffer: encodes sw/sh/sb into word address + byte enables,
// queues them for the data memory and forwards queued bytes to probing loads.
module dm_store_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    st_valid,
    input  logic [1:0]              st_sel,
    input  logic [31:0]             st_addr,
    input  logic [31:0]             st_wdata,
    output logic                    st_ready,
    output logic                    st_misalign,
    input  logic [31:0]             ld_addr,
    output logic [31:0]             ld_fwd_data,
    output logic [3:0]              ld_fwd_mask,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    output logic [3:0]              mem_be,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_ack,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] SEL_SW = 2'b00;
    localparam logic [1:0] SEL_SB = 2'b01;
    localparam logic [1:0] SEL_SH = 2'b10;

    logic [PW-1:0] wrPtrReg;
    logic [PW-1:0] rdPtrReg;
    logic [CW-1:0] countReg;

    logic [29:0] entryAddr [DEPTH];
    logic [3:0]  entryBe   [DEPTH];
    logic [31:0] entryData [DEPTH];

    logic [3:0]  encBe;
    logic [31:0] encData;
    logic        encMis;
    logic        encIsStore;
    logic        doPush;
    logic        doPop;

    // Only the word address of a load matters for forwarding.
    logic unusedLdBits;
    assign unusedLdBits = ^ld_addr[1:0];

    always_comb begin
        encBe      = 4'b0000;
        encData    = st_wdata;
        encMis     = 1'b0;
        encIsStore = 1'b1;
        case (st_sel)
            SEL_SW: begin
                encBe  = 4'b1111;
                encMis = (st_addr[1:0] != 2'b00);
            end
            SEL_SB: begin
                encBe   = 4'b0001 << st_addr[1:0];
                encData = {4{st_wdata[7:0]}};
            end
            SEL_SH: begin
                encBe   = st_addr[1] ? 4'b1100 : 4'b0011;
                encData = {2{st_wdata[15:0]}};
                encMis  = st_addr[0];
            end
            default: begin
                encIsStore = 1'b0;
            end
        endcase
    end

    assign st_misalign = st_valid & encMis;
    assign st_ready    = (countReg < CW'(DEPTH));
    assign doPush      = st_valid & st_ready & encIsStore & ~encMis;
    assign mem_req     = (countReg != '0);
    assign doPop       = mem_req & mem_ack;
    assign count       = countReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PW'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + CW'(1);
                2'b01:   countReg <= countReg - CW'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    // Entry payload carries no reset; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            entryAddr[wrPtrReg] <= st_addr[31:2];
            entryBe[wrPtrReg]   <= encBe;
            entryData[wrPtrReg] <= encData;
        end
    end

    // Outputs are gated so an empty buffer presents zeros on the memory port.
    assign mem_addr  = mem_req ? {entryAddr[rdPtrReg], 2'b00} : 32'd0;
    assign mem_be    = mem_req ? entryBe[rdPtrReg] : 4'b0000;
    assign mem_wdata = mem_req ? entryData[rdPtrReg] : 32'd0;

    // Slot gi is the gi-th oldest entry; slot 0 is the head.
    logic [PW-1:0]    slotIdx [DEPTH];
    logic [DEPTH-1:0] slotHit;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slotIdx[gi] = rdPtrReg + PW'(gi);
        assign slotHit[gi] = (CW'(gi) < countReg) &&
                             (entryAddr[slotIdx[gi]] == ld_addr[31:2]);
    end

    // Walking oldest to youngest lets the youngest matching byte win.
    always_comb begin
        ld_fwd_mask = 4'b0000;
        ld_fwd_data = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slotHit[k]) begin
                for (int b = 0; b < 4; b++) begin
                    if (entryBe[slotIdx[k]][b]) begin
                        ld_fwd_mask[b]          = 1'b1;
                        ld_fwd_data[8*b +: 8]   = entryData[slotIdx[k]][8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: directed scenarios plus a randomized drain
// phase, checked against a queue-based model of the buffer contents.
module tb_dm_store_buffer;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } st_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic [1:0]  st_sel = 2'b11;
    logic [31:0] st_addr = 32'd0;
    logic [31:0] st_wdata = 32'd0;
    logic        st_ready;
    logic        st_misalign;
    logic [31:0] ld_addr = 32'd0;
    logic [31:0] ld_fwd_data;
    logic [3:0]  ld_fwd_mask;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [$clog2(DEPTH):0] count;

    int   tests = 0;
    int   fails = 0;
    logic started = 1'b0;
    logic ackRand = 1'b0;
    logic ldRand = 1'b0;

    st_t expQ[$];   // scoreboard: stores issued, in the order memory must see them
    st_t refQ[$];   // model of buffer contents, index 0 = oldest

    dm_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_sel(st_sel), .st_addr(st_addr), .st_wdata(st_wdata),
        .st_ready(st_ready), .st_misalign(st_misalign),
        .ld_addr(ld_addr), .ld_fwd_data(ld_fwd_data), .ld_fwd_mask(ld_fwd_mask),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void encode(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d,
                                   output st_t e, output logic mis, output logic isSt);
        logic [1:0] off;
        off    = a[1:0];
        e.addr = a & ~32'd3;
        e.be   = 4'b0000;
        e.data = 32'd0;
        mis    = 1'b0;
        isSt   = 1'b1;
        case (sel)
            2'b00: begin e.be = 4'b1111; e.data = d; mis = (off != 2'd0); end
            2'b01: begin e.be = 4'b0001 << off; e.data = {4{d[7:0]}}; end
            2'b10: begin e.be = (off >= 2'd2) ? 4'b1100 : 4'b0011; e.data = {2{d[15:0]}}; mis = off[0]; end
            default: isSt = 1'b0;
        endcase
    endfunction

    function automatic void ref_fwd(input logic [31:0] la, output logic [3:0] m, output logic [31:0] d);
        m = 4'b0000;
        d = 32'd0;
        foreach (refQ[k]) begin
            if (refQ[k].addr == (la & ~32'd3)) begin
                for (int b = 0; b < 4; b++) begin
                    if (refQ[k].be[b]) begin
                        m[b] = 1'b1;
                        d[8*b +: 8] = refQ[k].data[8*b +: 8];
                    end
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (ackRand) mem_ack = 1'($urandom_range(0, 1));
        if (ldRand) ld_addr = 32'h4000 + 32'($urandom_range(0, 15));
    endtask

    task automatic do_store(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d,
                            output logic took);
        st_t  e;
        logic mis, isSt, rdy;
        int   w;
        encode(sel, a, d, e, mis, isSt);
        st_valid = 1'b1;
        st_sel   = sel;
        st_addr  = a;
        st_wdata = d;
        took     = isSt && !mis;
        $display("[TB] store sel=%b addr=%h data=%h %s", sel, a, d, took ? "queued" : "dropped");
        if (took) begin
            expQ.push_back(e);
            w = 0;
            do begin
                @(negedge clk);
                rdy = st_ready;
                tick();
                w++;
            end while (!rdy && w < 100);
            chk("store_accept", 32'(rdy), 32'd1);
        end else begin
            tick();
        end
    endtask

    // Monitor: compares every cycle against refQ, and pops the scoreboard on each handshake.
    initial begin
        forever begin
            st_t         e, h;
            logic        mis, isSt;
            logic [3:0]  m;
            logic [31:0] fd;
            int          sz;
            @(negedge clk);
            if (!reset) begin
                refQ.delete();
                continue;
            end
            if (!started) continue;
            encode(st_sel, st_addr, st_wdata, e, mis, isSt);
            sz = refQ.size();
            chk("st_misalign", 32'(st_misalign), 32'(st_valid && mis));
            chk("count", 32'(count), 32'(sz));
            chk("st_ready", 32'(st_ready), 32'(sz < DEPTH));
            chk("mem_req", 32'(mem_req), 32'(sz != 0));
            ref_fwd(ld_addr, m, fd);
            chk("fwd_mask", 32'(ld_fwd_mask), 32'(m));
            chk("fwd_data", ld_fwd_data, fd);
            if (sz != 0) begin
                chk("head_addr", mem_addr, refQ[0].addr);
                chk("head_be", 32'(mem_be), 32'(refQ[0].be));
                chk("head_data", mem_wdata, refQ[0].data);
                if (mem_ack) begin
                    if (expQ.size() == 0) begin
                        chk("sb_nonempty", 32'(expQ.size()), 32'd1);
                    end else begin
                        h = expQ.pop_front();
                        chk("sb_addr", mem_addr, h.addr);
                        chk("sb_be", 32'(mem_be), 32'(h.be));
                        chk("sb_data", mem_wdata, h.data);
                        $display("[TB] mem write addr=%h be=%b data=%h", mem_addr, mem_be, mem_wdata);
                    end
                    void'(refQ.pop_front());
                end
            end
            if (st_valid && isSt && !mis && sz < DEPTH) refQ.push_back(e);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tk;
        st_t  e3;
        logic m3, s3;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        started = 1'b1;
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_fwd_mask", 32'(ld_fwd_mask), 32'd0);
        chk("rst_fwd_data", ld_fwd_data, 32'd0);
        tick();

        // sb at 0x1003, then one ack
        mem_ack = 1'b0;
        do_store(2'b01, 32'h1003, 32'h000000AB, tk);
        st_valid = 1'b0;
        @(negedge clk);
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_addr", mem_addr, 32'h1000);
        chk("t1_be", 32'(mem_be), 32'b1000);
        chk("t1_data", mem_wdata, 32'hABABABAB);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t1_count", 32'(count), 32'd0);
        tick();

        // halfword lanes and misalignment
        do_store(2'b10, 32'h2002, 32'h00001234, tk);
        st_valid = 1'b0;
        @(negedge clk);
        chk("t2_be", 32'(mem_be), 32'b1100);
        chk("t2_data", mem_wdata, 32'h12341234);
        tick();
        st_valid = 1'b1; st_sel = 2'b10; st_addr = 32'h2001; st_wdata = 32'h5678;
        @(negedge clk);
        chk("t2_sh_misalign", 32'(st_misalign), 32'd1);
        tick();
        st_sel = 2'b00; st_addr = 32'h2006;
        @(negedge clk);
        chk("t2_sw_misalign", 32'(st_misalign), 32'd1);
        chk("t2_count", 32'(count), 32'd1);
        tick();
        st_sel = 2'b11; st_addr = 32'h2001;
        @(negedge clk);
        chk("t2_nostore_misalign", 32'(st_misalign), 32'd0);
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t2_count_after", 32'(count), 32'd1);
        tick();
        mem_ack = 1'b1;
        repeat (2) tick();
        mem_ack = 1'b0;

        // fill to DEPTH, third store held off; pop while full does not admit it
        do_store(2'b00, 32'h0100, 32'hA0A0A0A0, tk);
        do_store(2'b00, 32'h0104, 32'hB1B1B1B1, tk);
        st_valid = 1'b1; st_sel = 2'b00; st_addr = 32'h0108; st_wdata = 32'hC2C2C2C2;
        encode(2'b00, 32'h0108, 32'hC2C2C2C2, e3, m3, s3);
        expQ.push_back(e3);
        @(negedge clk);
        chk("t3_ready_full", 32'(st_ready), 32'd0);
        chk("t3_count_full", 32'(count), 32'd2);
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        chk("t3_ready_during_pop", 32'(st_ready), 32'd0);
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t3_count_after_pop", 32'(count), 32'd1);
        chk("t3_ready_after_pop", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t3_count_after_push", 32'(count), 32'd2);
        tick();
        mem_ack = 1'b1;
        repeat (3) tick();
        mem_ack = 1'b0;

        // forwarding: youngest byte wins, other word misses
        do_store(2'b00, 32'h3000, 32'h11223344, tk);
        do_store(2'b01, 32'h3001, 32'h000000EE, tk);
        st_valid = 1'b0;
        ld_addr = 32'h3000;
        @(negedge clk);
        chk("t4_mask", 32'(ld_fwd_mask), 32'b1111);
        chk("t4_data", ld_fwd_data, 32'h1122EE44);
        tick();
        ld_addr = 32'h3004;
        @(negedge clk);
        chk("t4_miss_mask", 32'(ld_fwd_mask), 32'd0);
        chk("t4_miss_data", ld_fwd_data, 32'd0);
        tick();
        mem_ack = 1'b1;
        repeat (3) tick();

        // mem_ack tied high: back-to-back stores
        for (int k = 0; k < 6; k++) do_store(2'b00, 32'h5000 + 32'(4 * k), $urandom, tk);
        st_valid = 1'b0;
        repeat (2) tick();

        // randomized mix with random ack and random probes
        ackRand = 1'b1;
        ldRand = 1'b1;
        for (int n = 0, it = 0; n < 40 && it < 2000; it++) begin
            logic [1:0]  sel;
            logic [31:0] a, d;
            sel = 2'($urandom_range(0, 3));
            a   = 32'h4000 + 32'($urandom_range(0, 15));
            d   = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                st_valid = 1'b0;
                tick();
            end else begin
                do_store(sel, a, d, tk);
                if (tk) n++;
            end
        end
        ackRand = 1'b0;
        ldRand = 1'b0;
        st_valid = 1'b0;
        mem_ack = 1'b1;
        repeat (4) tick();
        chk("all_drained", 32'(expQ.size()), 32'd0);

        // asynchronous reset with a full buffer
        mem_ack = 1'b0;
        do_store(2'b00, 32'h6000, 32'hDEADBEEF, tk);
        do_store(2'b01, 32'h6005, 32'h00000077, tk);
        st_valid = 1'b0;
        #1;
        chk("t7_count_before", 32'(count), 32'd2);
        chk("t7_req_before", 32'(mem_req), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("t7_req_async", 32'(mem_req), 32'd0);
        chk("t7_count_async", 32'(count), 32'd0);
        expQ.delete();
        repeat (2) tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t7_req_after", 32'(mem_req), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Memory-stage store unit for the pipelined CPU: the write-side counterpart of the writeback load extractor. It converts sw/sh/sb requests into a word-aligned address, byte-enable mask and lane-replicated write data, queues them in a small FIFO, and drains them to the data memory over a req/ack port. Loads probe the queue and receive per-byte forwarded data so that writeback byte extraction sees the youngest stored value.

## Interface
- DEPTH, 2, number of buffer entries; power of two, at least 2
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- st_valid  in  1  M stage presents a store this cycle
- st_sel  in  2  00 sw, 01 sb, 10 sh, 11 no store
- st_addr  in  32  byte address from the ALU
- st_wdata  in  32  unshifted rt value
- st_ready  out  1  buffer can accept a store (count < DEPTH)
- st_misalign  out  1  combinational: presented store is misaligned
- ld_addr  in  32  byte address of the load being probed
- ld_fwd_data  out  32  forwarded bytes, in memory lane positions
- ld_fwd_mask  out  4  bit i set: byte lane i of ld_fwd_data is valid
- mem_req  out  1  head entry is valid and offered to memory
- mem_addr  out  32  head word address, bits [1:0] = 00
- mem_be  out  4  head byte enables
- mem_wdata  out  32  head write data
- mem_ack  in  1  memory accepts the head entry this cycle
- count  out  log2(DEPTH)+1  occupied entries

## Operation
- Lane encoding (b = addr[1:0]):
  - sw: be = 1111, data = st_wdata; misaligned if b != 00
  - sh: be = 0011 if b[1]=0 else 1100; data = {2{st_wdata[15:0]}}; misaligned if b[0]=1
  - sb: be = 0001 << b; data = {4{st_wdata[7:0]}}
  - st_sel 11: never a store; st_misalign = 0
- st_misalign = st_valid & misaligned-per-above; purely combinational, independent of st_ready.
- Push when st_valid & st_ready & !st_misalign & st_sel != 11. Entry stores {addr[31:2], be, data}. Write pointer advances modulo DEPTH.
- Misaligned or st_sel 11 requests never enter the buffer, regardless of st_ready.
- Pop when mem_req & mem_ack; read pointer advances modulo DEPTH.
- mem_req = (count != 0). mem_addr/mem_be/mem_wdata come from the head entry and stay stable until popped. mem_ack while mem_req = 0 is ignored.
- st_ready is computed from the registered count only. A push and a pop in the same cycle are both performed; count is unchanged. When full, a same-cycle pop does not enable a push.
- Forwarding is combinational. For each byte lane i, ld_fwd_mask[i] = 1 if any valid entry has a matching word address (addr[31:2]) and be[i] = 1. ld_fwd_data lane i comes from the youngest such entry. An entry popped this cycle still forwards this cycle. A store pushed this cycle is not visible until the next cycle. Lanes with mask 0 drive 0.
- The pipeline stalls M on st_valid & !st_ready. That stall logic is outside this block.

## Timing
- Reset (asynchronous assert, synchronous release to the clk domain): count 0, both pointers 0, mem_req 0, mem_addr/mem_be/mem_wdata 0, ld_fwd_mask 0, ld_fwd_data 0. Entry contents are don't-care but invalid.
- Latency: a store pushed at edge N is on the memory port (mem_req = 1) after edge N, and is forwardable from the cycle after edge N.
- With mem_ack tied high, throughput is one store per cycle and count never exceeds 1.
- Wrap-around: pointers wrap DEPTH-1 → 0 with no bubble.
- Reset mid-drain: all queued stores are discarded and mem_req drops immediately (asynchronous).

## Test plan
- After reset, sb at 0x1003 with wdata 0x000000AB -> next cycle mem_req=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB; with mem_ack=1 one cycle -> count=0.
- sh at 0x2002 with data 0x1234, then sh at 0x2001 -> first: be=1100, data=0x12341234. Second: st_misalign=1, count unchanged. sw at 0x2006 -> st_misalign=1.
- mem_ack held 0, DEPTH=2, three consecutive sw -> st_ready=0 after the second push, third held off, count=2. Raise mem_ack for one cycle with the store still presented -> pop occurs, no push that cycle, push on the next cycle.
- mem_ack=0; sw 0x3000=0x11223344, then sb 0x3001=0xEE; probe ld_addr 0x3000 -> mask=1111, data=0x1122EE44. Probe 0x3004 -> mask=0000, data=0.
- Mixed pushes with random mem_ack over 40 stores, DEPTH=2 -> memory receives every store in order with the correct be/data; pointers wrap cleanly.
- Assert reset with count=2 and mem_req=1 -> mem_req=0 and count=0 immediately, without waiting for a clk edge.
